mutative_tag_ctrl: RTL

- Port controller and initiator for the 128x21 single-port tag SRAM (`mutative_tag_array`). Sits between the cache control FSM and the macro.
- Accepts tag lookup and tag write requests through a valid/ready handshake and drives the SRAM `csb0`/`web0`/`addr0`/`din0` pins.
- Captures `dout0` and returns a hit/miss response.
- After reset or flush, sweeps all 128 entries to invalid before accepting requests.

---
 rtl/mutative_tag_pkg.sv | 18 +
 rtl/mutative_tag_ctrl_if.sv | 25 ++
 rtl/mutative_tag_sweep.sv | 29 ++
 rtl/mutative_tag_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/mutative_tag_pkg.sv
// Shared constants and types for the tag SRAM port controller.
package mutative_tag_pkg;

    localparam int unsigned TAG_W  = 20;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned WORD_W = TAG_W + 1;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_word_t;

endpackage

// File: rtl/mutative_tag_ctrl_if.sv
// Request/response bus between the cache control FSM (master) and the tag controller (slave).
interface mutative_tag_ctrl_if;
    import mutative_tag_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             req_wvalid;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_write, req_index, req_tag, req_wvalid,
        input  req_ready, rsp_valid, rsp_hit, rsp_tag
    );

    modport slave (
        input  req_valid, req_write, req_index, req_tag, req_wvalid,
        output req_ready, rsp_valid, rsp_hit, rsp_tag
    );

endinterface

// File: rtl/mutative_tag_sweep.sv
// Address counter for the invalidation sweep; start restarts at 0, done flags the last entry.
module mutative_tag_sweep
    import mutative_tag_pkg::*;
(
    input  logic             clk0,
    input  logic             rst0,
    input  logic             start,
    input  logic             en,
    output logic [IDX_W-1:0] count,
    output logic             done
);

    logic [IDX_W-1:0] count_q;

    // Wraps to 0 after the last entry, so a finished sweep leaves the counter ready to reuse.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + IDX_W'(1);
        end
    end

    assign count = count_q;
    assign done  = (count_q == {IDX_W{1'b1}});

endmodule

// File: rtl/mutative_tag_ctrl.sv
// Tag SRAM port controller: invalidation sweep, lookup/write issue, hit/miss response.
// Optional hit/miss counters are enabled by defining MUTATIVE_TAG_STATS_EN.
module mutative_tag_ctrl
    import mutative_tag_pkg::*;
(
    input  logic              clk0,
    input  logic              rst0,
    input  logic              flush,
    mutative_tag_ctrl_if.slave bus,
    output logic              init_busy,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [IDX_W-1:0]  sram_addr0,
    output logic [WORD_W-1:0] sram_din0,
    input  logic [WORD_W-1:0] sram_dout0
`ifdef MUTATIVE_TAG_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    state_e           state_q;
    logic             rsp_valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] sweep_count;
    logic             sweep_done;
    logic             accept;
    logic             lookup;
    tag_word_t        wr_word;
    tag_word_t        rd_word;

    mutative_tag_sweep u_sweep (
        .clk0  (clk0),
        .rst0  (rst0),
        .start (flush),
        .en    (state_q == INIT),
        .count (sweep_count),
        .done  (sweep_done)
    );

    assign bus.req_ready = (state_q == RUN) && !flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign lookup        = accept && !bus.req_write;
    assign init_busy     = (state_q == INIT);

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q     <= INIT;
            rsp_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            // Flush does not cancel a lookup already accepted; its response still appears.
            rsp_valid_q <= lookup;
            if (lookup) begin
                tag_q <= bus.req_tag;
            end
            unique case (state_q)
                INIT: if (!flush && sweep_done) state_q <= RUN;
                RUN:  if (flush) state_q <= INIT;
            endcase
        end
    end

    always_comb begin
        wr_word.valid = bus.req_wvalid;
        wr_word.tag   = bus.req_tag;
        sram_csb0     = 1'b1;
        sram_web0     = 1'b1;
        sram_addr0    = '0;
        sram_din0     = '0;
        // Chip select stays high while reset is held so the macro sees no access.
        if (!rst0) begin
            if (state_q == INIT) begin
                sram_csb0  = 1'b0;
                sram_web0  = 1'b0;
                sram_addr0 = sweep_count;
            end else if (accept) begin
                sram_csb0  = 1'b0;
                sram_web0  = !bus.req_write;
                sram_addr0 = bus.req_index;
                sram_din0  = wr_word;
            end
        end
    end

    assign rd_word       = sram_dout0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_valid_q && rd_word.valid && (rd_word.tag == tag_q);
    assign bus.rsp_tag   = rsp_valid_q ? rd_word.tag : '0;

`ifdef MUTATIVE_TAG_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (flush) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (rsp_valid_q) begin
            if (bus.rsp_hit) begin
                if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
            end else begin
                if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule
